// File: rtl/note_lane_scheduler.sv
// note_lane_scheduler: per-frame motion/gameplay controller for five note lanes.
// Spawns notes, advances each active note once per video frame (one lane per
// cycle in UPDATE), resolves key hits against the hit window, retires notes at
// the bottom and keeps a saturating hit score.
// Optional build macro SPEED_RAMP_EN: fall speed ramps up with the score.
module note_lane_scheduler #(
   parameter int SPEED     = 2,
   parameter int SPAWN_Y   = 0,
   parameter int BOTTOM_Y  = 480,
   parameter int HIT_Y     = 400,
   parameter int HIT_WIN   = 32,
   parameter int SPRITE_SZ = 64,
   parameter int LANE_X0   = 96,
   parameter int LANE_X1   = 192,
   parameter int LANE_X2   = 288,
   parameter int LANE_X3   = 384,
   parameter int LANE_X4   = 480
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_clk,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   input  logic        spawn_valid,
   input  logic [2:0]  spawn_lane,
   output logic        spawn_ready,
   input  logic [4:0]  hit_req,
   output logic [49:0] lane_x_pos,
   output logic [49:0] lane_y_pos,
   output logic [4:0]  is_sprite,
   output logic [4:0]  hit_ok,
   output logic [4:0]  miss,
   output logic [15:0] score,
   output logic        busy
);

   localparam logic [9:0]  P_SPAWN_Y = 10'(SPAWN_Y);
   localparam logic [10:0] P_BOTTOM  = 11'(BOTTOM_Y);
   localparam logic [10:0] P_HIT_LO  = 11'(HIT_Y);
   localparam logic [10:0] P_HIT_HI  = 11'(HIT_Y + HIT_WIN);
   localparam logic [10:0] P_SZ      = 11'(SPRITE_SZ);

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_UPDATE = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [2:0]  r_lane;
   logic [4:0]  r_active;
   logic [4:0]  r_pending;
   logic [4:0]  r_hit_ok;
   logic [4:0]  r_miss;
   logic [9:0]  r_y [5];
   logic [15:0] r_score;
   logic        r_frame_q;

   logic        w_frame_edge;
   logic [5:0]  w_speed;
   logic [9:0]  w_lane_x [5];
   logic [10:0] w_y_next [5];
   logic [4:0]  w_in_win;
   logic [4:0]  w_hits;
   logic [4:0]  w_hit_mask;
   logic [4:0]  w_miss_mask;
   logic [2:0]  w_hit_cnt;
   logic [16:0] w_score_sum;
   logic [15:0] w_score_next;
   logic [7:0]  w_active8;
   logic        w_spawn_ready;
   logic        w_spawn_fire;
   logic [4:0]  w_spawn_mask;

`ifdef SPEED_RAMP_EN
   logic [5:0]  r_speed;
   assign w_speed = r_speed;
`else
   assign w_speed = 6'(SPEED);
`endif

   assign w_lane_x[0] = 10'(LANE_X0);
   assign w_lane_x[1] = 10'(LANE_X1);
   assign w_lane_x[2] = 10'(LANE_X2);
   assign w_lane_x[3] = 10'(LANE_X3);
   assign w_lane_x[4] = 10'(LANE_X4);

   assign w_frame_edge = frame_clk & ~r_frame_q;

   // Spawn handshake: a request transfers on a cycle where spawn_valid and
   // spawn_ready are both high. Ready only in IDLE, for a legal lane that has
   // no live note; the requester holds or retries otherwise.
   assign w_active8     = {3'b000, r_active};
   assign w_spawn_ready = (r_state == S_IDLE) && (spawn_lane <= 3'd4) && !w_active8[spawn_lane];
   assign w_spawn_fire  = spawn_valid && w_spawn_ready;
   assign w_spawn_mask  = w_spawn_fire ? (5'b00001 << spawn_lane) : 5'b00000;

   // Hits seen this cycle are folded in with the latched ones when consumed.
   assign w_hits      = r_pending | hit_req;
   assign w_hit_mask  = (r_state == S_IDLE) ? (w_hits & w_in_win) : 5'b00000;
   assign w_miss_mask = (r_state == S_IDLE) ? (w_hits & ~w_in_win) : 5'b00000;
   assign w_score_sum  = {1'b0, r_score} + {14'b0, w_hit_cnt};
   assign w_score_next = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];

   // Per-lane window test, next Y, sprite coverage and hit count (11-bit compares, no wrap).
   always_comb begin
      w_in_win  = '0;
      is_sprite = '0;
      w_hit_cnt = '0;
      w_y_next  = '{default: '0};
      for (int l = 0; l < 5; l++) begin
         w_in_win[l]  = r_active[l] && ({1'b0, r_y[l]} >= P_HIT_LO) && ({1'b0, r_y[l]} <= P_HIT_HI);
         w_y_next[l]  = {1'b0, r_y[l]} + {5'b0, w_speed};
         is_sprite[l] = r_active[l]
                     && ({1'b0, DrawX} >= {1'b0, w_lane_x[l]})
                     && ({1'b0, DrawX} <  ({1'b0, w_lane_x[l]} + P_SZ))
                     && ({1'b0, DrawY} >= {1'b0, r_y[l]})
                     && ({1'b0, DrawY} <  ({1'b0, r_y[l]} + P_SZ));
         w_hit_cnt    = w_hit_cnt + {2'b0, w_hit_mask[l]};
      end
   end

   // FSM next state: a frame edge starts a five-cycle sweep; edges in UPDATE are dropped.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:   if (w_frame_edge) w_state_next = S_UPDATE;
         S_UPDATE: if (r_lane == 3'd4) w_state_next = S_IDLE;
         default:  w_state_next = S_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge Clk) begin
      if (Reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   // Note datapath: hit resolution and spawns in IDLE, one-lane motion step in UPDATE.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_frame_q <= frame_clk;
         r_lane    <= '0;
         r_active  <= '0;
         r_pending <= '0;
         r_hit_ok  <= '0;
         r_miss    <= '0;
         r_score   <= '0;
         for (int l = 0; l < 5; l++) r_y[l] <= P_SPAWN_Y;
      end else begin
         r_frame_q <= frame_clk;
         r_hit_ok  <= '0;
         r_miss    <= '0;
         if (r_state == S_IDLE) begin
            r_lane    <= '0;
            r_pending <= '0;
            r_hit_ok  <= w_hit_mask;
            r_miss    <= w_miss_mask;
            r_score   <= w_score_next;
            r_active  <= (r_active & ~w_hit_mask) | w_spawn_mask;
            for (int l = 0; l < 5; l++)
               if (w_spawn_mask[l]) r_y[l] <= P_SPAWN_Y;
         end else begin
            r_lane    <= r_lane + 3'd1;
            r_pending <= r_pending | hit_req;
            for (int l = 0; l < 5; l++) begin
               if ((r_lane == 3'(l)) && r_active[l]) begin
                  if (w_y_next[l] >= P_BOTTOM) begin
                     r_active[l] <= 1'b0;
                     r_y[l]      <= P_SPAWN_Y;
                     r_miss[l]   <= 1'b1;
                  end else begin
                     r_y[l]      <= w_y_next[l][9:0];
                  end
               end
            end
         end
      end
   end

`ifdef SPEED_RAMP_EN
   // Speed ramp: one step each time the score crosses a multiple of 16, capped at 8.
   always_ff @(posedge Clk) begin
      if (Reset)
         r_speed <= 6'(SPEED);
      else if ((r_state == S_IDLE) && (w_score_next[15:4] != r_score[15:4]) && (r_speed < 6'd8))
         r_speed <= r_speed + 6'd1;
   end
`endif

   assign spawn_ready = w_spawn_ready;
   assign lane_x_pos  = {w_lane_x[4], w_lane_x[3], w_lane_x[2], w_lane_x[1], w_lane_x[0]};
   assign lane_y_pos  = {r_y[4], r_y[3], r_y[2], r_y[1], r_y[0]};
   assign hit_ok      = r_hit_ok;
   assign miss        = r_miss;
   assign score       = r_score;
   assign busy        = (r_state == S_UPDATE);

endmodule
